noc_vc_fifo: RTL
================

Name: noc_vc_fifo

Overview:
- Next-generation input buffer for the 5-port NoC router; one instance sits behind each router input port.
- Holds NUM_VC independent virtual-channel FIFOs of 2**DEPTH_LOG2 flits each, WIDTH bits wide, in one storage array partitioned per VC.
- Provides per-VC empty/full/occupancy, a registered read port, a credit-return pulse toward the upstream router, and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 16, flit width in bits
- DEPTH_LOG2, 4, log2 of entries per VC (16 entries per VC)
- NUM_VC, 4, number of virtual channels; must be >= 2
- AFULL_MARGIN, 2, almost-full threshold margin (used only with the optional feature)
- Derived localparams, not overridable: VC_W = $clog2(NUM_VC); CNT_W = DEPTH_LOG2+1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  1  write request
- wr_vc  in  VC_W  target VC for the write
- wr_data  in  WIDTH  flit to write
- rd_en  in  1  read request
- rd_vc  in  VC_W  VC to read
- rd_data  out  WIDTH  registered read flit
- rd_valid  out  1  rd_data holds a flit popped in the previous cycle
- empty  out  NUM_VC  per-VC empty
- full  out  NUM_VC  per-VC full
- occupancy  out  NUM_VC*CNT_W  per-VC count, packed; VC0 in the LSBs
- credit_ret  out  1  one-cycle pulse, one flit freed
- credit_vc  out  VC_W  VC of the freed slot, valid when credit_ret=1
- ovf_err  out  1  sticky: write attempted to a full VC
- udf_err  out  1  sticky: read attempted from an empty VC

Behaviour:
- Reset (async assert, sync release) clears all pointers and counts. Reset values:
  - empty = all 1s
  - full = 0, occupancy = 0
  - rd_data = 0, rd_valid = 0
  - credit_ret = 0, credit_vc = 0
  - ovf_err = 0, udf_err = 0
- Storage contents are not reset.
- Per VC: read pointer and write pointer, each DEPTH_LOG2 bits, plus a CNT_W counter.
  - Pointers wrap modulo 2**DEPTH_LOG2.
  - empty = (count == 0); full = (count == 2**DEPTH_LOG2).
  - Flags and occupancy are driven from registered counts and reflect every accepted write/read in the cycle after the clock edge.
- Write is accepted iff wr_en=1 and full[wr_vc]=0, evaluated on the pre-edge state.
  - Accepted: store wr_data at that VC's write pointer, increment the pointer.
  - wr_en=1 with full[wr_vc]=1: write dropped, ovf_err set.
- Read is accepted iff rd_en=1 and empty[rd_vc]=0, evaluated on the pre-edge state.
  - Accepted: rd_data <= entry at the read pointer, rd_valid <= 1, increment the read pointer; credit_ret <= 1 and credit_vc <= rd_vc on the same edge.
  - Otherwise rd_valid <= 0, credit_ret <= 0, rd_data holds its last value.
  - rd_en=1 with empty[rd_vc]=1: udf_err set, no pointer change.
- Read latency: one cycle from the rd_en edge to rd_data/rd_valid.
- Simultaneous write and read:
  - Different VCs: independent.
  - Same non-empty, non-full VC: both accepted, count unchanged.
  - Same VC that is full: read accepted, write dropped with ovf_err (no pass-through).
  - Same VC that is empty: write accepted, read rejected with udf_err (no bypass).
- ovf_err and udf_err stay set until reset.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- Out-of-range VC index (wr_vc or rd_vc >= NUM_VC when NUM_VC is not a power of two): request ignored, no error flag set.

Optional Feature:
- Macro: NOC_VC_FIFO_AFULL_EN
- Defined: adds output almost_full [NUM_VC]; almost_full[v] = (count[v] >= 2**DEPTH_LOG2 - AFULL_MARGIN), registered and reset to 0. Upstream throttles on it.
- Undefined: the port does not exist and AFULL_MARGIN is ignored.

Test Plan:
- Reset, then write 16'h20, 16'h127, 16'h32, 16'h763, 16'h98 to VC0 -> occupancy[VC0]=5, empty[0]=0, other VCs stay empty.
- Read VC0 five times -> rd_data = 16'h20, 16'h127, 16'h32, 16'h763, 16'h98, each one cycle after its rd_en; five credit_ret pulses with credit_vc=0; empty[0]=1 afterwards.
- Write 17 flits to VC2 -> full[2]=1 after the 16th write; the 17th write is dropped and ovf_err=1; reading back yields the first 16 values.
- With VC1 holding 3 flits, issue a simultaneous write(VC1, 16'hAAAA) and read(VC1) for 20 cycles -> occupancy[VC1] stays 3, data order preserved, pointers wrap past 15 without corruption.
- Read from empty VC3 -> rd_valid=0, no credit_ret, udf_err=1; with NOC_VC_FIFO_AFULL_EN defined, filling VC0 to 14 entries -> almost_full[0]=1.
- Assert rst_n low mid-burst, between clock edges -> all outputs return to reset values without a clock edge; after release, a write/read pair on VC0 with 16'h55 returns 16'h55.

Source files
------------

// File: rtl/noc_vc_fifo.sv
// noc_vc_fifo: per-input-port NoC router buffer holding NUM_VC virtual-channel
// FIFOs in one storage array, with a registered read port, credit return and
// sticky overflow/underflow flags.
// Optional build macro NOC_VC_FIFO_AFULL_EN adds a registered per-VC almost_full
// output (count >= depth - AFULL_MARGIN).
module noc_vc_fifo #(
    parameter int WIDTH        = 16,
    parameter int DEPTH_LOG2   = 4,
    parameter int NUM_VC       = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wr_en,
    input  logic [$clog2(NUM_VC)-1:0]                 wr_vc,
    input  logic [WIDTH-1:0]                          wr_data,
    input  logic                                      rd_en,
    input  logic [$clog2(NUM_VC)-1:0]                 rd_vc,
    output logic [WIDTH-1:0]                          rd_data,
    output logic                                      rd_valid,
    output logic [NUM_VC-1:0]                         empty,
    output logic [NUM_VC-1:0]                         full,
    output logic [NUM_VC*(DEPTH_LOG2+1)-1:0]          occupancy,
    output logic                                      credit_ret,
    output logic [$clog2(NUM_VC)-1:0]                 credit_vc,
    output logic                                      ovf_err,
    output logic                                      udf_err
`ifdef NOC_VC_FIFO_AFULL_EN
    ,
    output logic [NUM_VC-1:0]                         almost_full
`endif
);

    localparam int VC_W   = $clog2(NUM_VC);
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int ADDR_W = VC_W + DEPTH_LOG2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [VC_W:0]    NUM_VC_L = (VC_W + 1)'(NUM_VC);

    // Storage is addressed {vc, ptr}; VC slots beyond NUM_VC are never touched.
    logic [WIDTH-1:0]      mem_q [0:(1 << ADDR_W)-1];

    logic [DEPTH_LOG2-1:0] wptr_q [NUM_VC];
    logic [DEPTH_LOG2-1:0] wptr_d [NUM_VC];
    logic [DEPTH_LOG2-1:0] rptr_q [NUM_VC];
    logic [DEPTH_LOG2-1:0] rptr_d [NUM_VC];
    logic [CNT_W-1:0]      cnt_q  [NUM_VC];
    logic [CNT_W-1:0]      cnt_d  [NUM_VC];

    logic [WIDTH-1:0]      rd_data_q;
    logic                  rd_valid_q;
    logic                  credit_ret_q;
    logic [VC_W-1:0]       credit_vc_q;
    logic                  ovf_err_q;
    logic                  udf_err_q;

    logic                  wr_in_range, rd_in_range;
    logic                  wr_full_sel, rd_empty_sel;
    logic [DEPTH_LOG2-1:0] wr_ptr_sel, rd_ptr_sel;
    logic                  wr_ok, rd_ok, ovf_hit, udf_hit;

    // Requests naming a VC that does not exist are silently ignored.
    assign wr_in_range = ({1'b0, wr_vc} < NUM_VC_L);
    assign rd_in_range = ({1'b0, rd_vc} < NUM_VC_L);

    // Status from registered counts so flags follow each accepted op by one edge.
    for (genvar g = 0; g < NUM_VC; g++) begin : g_status
        assign empty[g]                     = (cnt_q[g] == '0);
        assign full[g]                      = (cnt_q[g] == FULL_CNT);
        assign occupancy[g*CNT_W +: CNT_W]  = cnt_q[g];
    end

    // Select the addressed VC's pointer and status without out-of-range indexing.
    always_comb begin
        wr_full_sel  = 1'b0;
        rd_empty_sel = 1'b1;
        wr_ptr_sel   = '0;
        rd_ptr_sel   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_vc == VC_W'(v)) begin
                wr_full_sel = full[v];
                wr_ptr_sel  = wptr_q[v];
            end
            if (rd_vc == VC_W'(v)) begin
                rd_empty_sel = empty[v];
                rd_ptr_sel   = rptr_q[v];
            end
        end
    end

    // Full VC drops the write, empty VC rejects the read: no pass-through or bypass.
    assign wr_ok   = wr_en && wr_in_range && !wr_full_sel;
    assign rd_ok   = rd_en && rd_in_range && !rd_empty_sel;
    assign ovf_hit = wr_en && wr_in_range && wr_full_sel;
    assign udf_hit = rd_en && rd_in_range && rd_empty_sel;

    // Next pointers and counts; a same-VC write+read leaves the count unchanged.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            wptr_d[v] = wptr_q[v];
            rptr_d[v] = rptr_q[v];
            cnt_d[v]  = cnt_q[v];
            if (wr_ok && (wr_vc == VC_W'(v))) begin
                wptr_d[v] = wptr_q[v] + DEPTH_LOG2'(1);
                cnt_d[v]  = cnt_d[v] + CNT_W'(1);
            end
            if (rd_ok && (rd_vc == VC_W'(v))) begin
                rptr_d[v] = rptr_q[v] + DEPTH_LOG2'(1);
                cnt_d[v]  = cnt_d[v] - CNT_W'(1);
            end
        end
    end

    // Flit storage; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[{wr_vc, wr_ptr_sel}] <= wr_data;
        end
    end

    // Pointer/count state and registered read port, credit and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wptr_q[v] <= '0;
                rptr_q[v] <= '0;
                cnt_q[v]  <= '0;
            end
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            credit_ret_q <= 1'b0;
            credit_vc_q  <= '0;
            ovf_err_q    <= 1'b0;
            udf_err_q    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                wptr_q[v] <= wptr_d[v];
                rptr_q[v] <= rptr_d[v];
                cnt_q[v]  <= cnt_d[v];
            end
            rd_valid_q   <= rd_ok;
            credit_ret_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q   <= mem_q[{rd_vc, rd_ptr_sel}];
                credit_vc_q <= rd_vc;
            end
            if (ovf_hit) begin
                ovf_err_q <= 1'b1;
            end
            if (udf_hit) begin
                udf_err_q <= 1'b1;
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign credit_ret = credit_ret_q;
    assign credit_vc  = credit_vc_q;
    assign ovf_err    = ovf_err_q;
    assign udf_err    = udf_err_q;

`ifdef NOC_VC_FIFO_AFULL_EN
    localparam logic [CNT_W-1:0] AFULL_TH = CNT_W'(DEPTH - AFULL_MARGIN);

    logic [NUM_VC-1:0] afull_q;

    // Almost-full computed from next counts so it lines up with occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            afull_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                afull_q[v] <= (cnt_d[v] >= AFULL_TH);
            end
        end
    end

    assign almost_full = afull_q;
`else
    // AFULL_MARGIN only matters when the almost-full output is built.
    if (AFULL_MARGIN < 0) begin : g_afull_margin_unused
    end
`endif

endmodule
